// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA timing engine: default 640x480@60 mode, sync polarity
// encodings and helpers that derive line/frame totals from porch and sync widths.
package vga_timing_pkg;

    localparam int unsigned DefHVisible = 640;
    localparam int unsigned DefHFront   = 16;
    localparam int unsigned DefHSync    = 96;
    localparam int unsigned DefHBack    = 48;
    localparam int unsigned DefVVisible = 480;
    localparam int unsigned DefVFront   = 10;
    localparam int unsigned DefVSync    = 2;
    localparam int unsigned DefVBack    = 33;
    localparam int unsigned DefColourW  = 12;
    localparam int unsigned DefClkDiv   = 4;

    localparam bit SyncActiveLow  = 1'b0;
    localparam bit SyncActiveHigh = 1'b1;

    function automatic int unsigned h_total(input int unsigned visible, input int unsigned front,
                                            input int unsigned sync, input int unsigned back);
        return visible + front + sync + back;
    endfunction

    function automatic int unsigned v_total(input int unsigned visible, input int unsigned front,
                                            input int unsigned sync, input int unsigned back);
        return visible + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_timing_engine_if.sv
// Pixel-side bus of the VGA timing engine: engine (master) publishes address and VGA outputs,
// colour client (slave) supplies colour. test_pattern exists only with VGA_TEST_PATTERN_EN.
interface vga_timing_engine_if #(
    parameter int unsigned HW       = 10,
    parameter int unsigned VW       = 10,
    parameter int unsigned COLOUR_W = 12
);
    logic [COLOUR_W-1:0] colour_in;
    logic [HW-1:0]       address_h;
    logic [VW-1:0]       address_v;
    logic                pixel_en;
    logic                display_en;
    logic                frame_start;
    logic [COLOUR_W-1:0] colour_out;
    logic                sync_h;
    logic                sync_v;
`ifdef VGA_TEST_PATTERN_EN
    logic                test_pattern;

    modport master (
        input  colour_in, test_pattern,
        output address_h, address_v, pixel_en, display_en, frame_start,
               colour_out, sync_h, sync_v
    );
    modport slave (
        output colour_in, test_pattern,
        input  address_h, address_v, pixel_en, display_en, frame_start,
               colour_out, sync_h, sync_v
    );
`else
    modport master (
        input  colour_in,
        output address_h, address_v, pixel_en, display_en, frame_start,
               colour_out, sync_h, sync_v
    );
    modport slave (
        output colour_in,
        input  address_h, address_v, pixel_en, display_en, frame_start,
               colour_out, sync_h, sync_v
    );
`endif
endinterface

// File: rtl/vga_pixel_tick.sv
// Divides the system clock by CLK_DIV into a one-cycle pixel strobe; first strobe arrives
// CLK_DIV cycles after reset is released.
module vga_pixel_tick #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic pixel_en
);
    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CntW-1:0] cnt_q;
    logic            tick_q;

    // Strobe is registered so reset holds it low even when CLK_DIV is 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= (cnt_q == CntW'(CLK_DIV - 1));
            cnt_q  <= (cnt_q == CntW'(CLK_DIV - 1)) ? '0 : cnt_q + CntW'(1);
        end
    end

    assign pixel_en = tick_q;

endmodule

// File: rtl/vga_timing_engine.sv
// Parametrised VGA timing generator: h/v counters, blanking, sync and a one-pixel output stage.
// Optional bar test pattern enabled by defining VGA_TEST_PATTERN_EN.
module vga_timing_engine
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE = DefHVisible,
    parameter int unsigned H_FRONT   = DefHFront,
    parameter int unsigned H_SYNC    = DefHSync,
    parameter int unsigned H_BACK    = DefHBack,
    parameter int unsigned V_VISIBLE = DefVVisible,
    parameter int unsigned V_FRONT   = DefVFront,
    parameter int unsigned V_SYNC    = DefVSync,
    parameter int unsigned V_BACK    = DefVBack,
    parameter int unsigned COLOUR_W  = DefColourW,
    parameter int unsigned CLK_DIV   = DefClkDiv,
    parameter bit          SYNC_POL  = SyncActiveLow
) (
    input logic                 clk,
    input logic                 reset,
    vga_timing_engine_if.master bus
);
    localparam int unsigned H_TOTAL    = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL    = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
    localparam int unsigned HW         = $clog2(H_TOTAL);
    localparam int unsigned VW         = $clog2(V_TOTAL);
    localparam int unsigned HSyncStart = H_VISIBLE + H_FRONT;
    localparam int unsigned HSyncEnd   = HSyncStart + H_SYNC;
    localparam int unsigned VSyncStart = V_VISIBLE + V_FRONT;
    localparam int unsigned VSyncEnd   = VSyncStart + V_SYNC;

    logic                pixel_en;
    logic [HW-1:0]       h_q;
    logic [VW-1:0]       v_q;
    logic                display_en;
    logic                h_sync_region;
    logic                v_sync_region;
    logic [COLOUR_W-1:0] pixel_colour;
    logic [COLOUR_W-1:0] colour_q;
    logic                sync_h_q;
    logic                sync_v_q;

    vga_pixel_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_pixel_tick (
        .clk     (clk),
        .reset   (reset),
        .pixel_en(pixel_en)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            h_q <= '0;
            v_q <= '0;
        end else if (pixel_en) begin
            if (h_q == HW'(H_TOTAL - 1)) begin
                h_q <= '0;
                v_q <= (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + VW'(1);
            end else begin
                h_q <= h_q + HW'(1);
            end
        end
    end

    assign display_en    = (32'(h_q) < H_VISIBLE) && (32'(v_q) < V_VISIBLE);
    assign h_sync_region = (32'(h_q) >= HSyncStart) && (32'(h_q) < HSyncEnd);
    assign v_sync_region = (32'(v_q) >= VSyncStart) && (32'(v_q) < VSyncEnd);

`ifdef VGA_TEST_PATTERN_EN
    localparam int unsigned FieldW = COLOUR_W / 3;
    logic [2:0] bar;

    // Eight equal bars across the visible width; bar index bits drive R, G and B fields.
    assign bar          = 3'((32'(h_q) << 3) / H_VISIBLE);
    assign pixel_colour = bus.test_pattern
                        ? COLOUR_W'({{FieldW{bar[2]}}, {FieldW{bar[1]}}, {FieldW{bar[0]}}})
                        : bus.colour_in;
`else
    assign pixel_colour = bus.colour_in;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            colour_q <= '0;
            sync_h_q <= ~SYNC_POL;
            sync_v_q <= ~SYNC_POL;
        end else if (pixel_en) begin
            colour_q <= display_en ? pixel_colour : '0;
            sync_h_q <= h_sync_region ? SYNC_POL : ~SYNC_POL;
            sync_v_q <= v_sync_region ? SYNC_POL : ~SYNC_POL;
        end
    end

    assign bus.address_h   = h_q;
    assign bus.address_v   = v_q;
    assign bus.pixel_en    = pixel_en;
    assign bus.display_en  = display_en;
    assign bus.frame_start = pixel_en && (h_q == '0) && (v_q == '0);
    assign bus.colour_out  = colour_q;
    assign bus.sync_h      = sync_h_q;
    assign bus.sync_v      = sync_v_q;

endmodule

// File: tb/tb_vga_timing_engine.sv
// Self-checking bench for vga_timing_engine in a small mode; expected behaviour comes from a
// time-indexed model (pixel index = elapsed cycles / CLK_DIV).
module tb_vga_timing_engine;

    localparam int HV  = 16;
    localparam int HF  = 2;
    localparam int HS  = 3;
    localparam int HB  = 2;
    localparam int VV  = 6;
    localparam int VF  = 1;
    localparam int VS  = 2;
    localparam int VB  = 1;
    localparam int DIV = 3;
    localparam int CW  = 12;
    localparam bit POL = 1'b0;
    localparam int HT  = HV + HF + HS + HB;
    localparam int VT  = VV + VF + VS + VB;
    localparam int HW  = $clog2(HT);
    localparam int VW  = $clog2(VT);
    localparam int FrameClks = HT * VT * DIV;

    logic clk = 1'b0;
    logic reset;
    logic tp_drv;
    int   total = 0;
    int   bad = 0;

    // Model state: cycles since reset release and the expected registered outputs.
    int          t;
    logic [CW-1:0] m_col;
    logic        m_sh;
    logic        m_sv;

    vga_timing_engine_if #(.HW(HW), .VW(VW), .COLOUR_W(CW)) bus ();

`ifdef VGA_TEST_PATTERN_EN
    assign bus.test_pattern = tp_drv;
`endif

    vga_timing_engine #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .COLOUR_W(CW), .CLK_DIV(DIV), .SYNC_POL(POL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic int pix_idx(input int tt);
        return (tt == 0) ? 0 : (tt - 1) / DIV;
    endfunction
    function automatic int mh(input int tt);
        return pix_idx(tt) % HT;
    endfunction
    function automatic int mv(input int tt);
        return (pix_idx(tt) / HT) % VT;
    endfunction
    function automatic bit m_pe(input int tt);
        return (tt > 0) && (tt % DIV == 0);
    endfunction
    function automatic bit in_rg(input int x, input int start, input int width);
        return (x >= start) && (x < start + width);
    endfunction
    function automatic logic [CW-1:0] bar_col(input int hh);
        logic [2:0] b;
        b = 3'(hh * 8 / HV);
        return {{4{b[2]}}, {4{b[1]}}, {4{b[0]}}};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            t     <= 0;
            m_col <= '0;
            m_sh  <= ~POL;
            m_sv  <= ~POL;
        end else begin
            if (m_pe(t)) begin
                if (mh(t) < HV && mv(t) < VV)
                    m_col <= tp_drv ? bar_col(mh(t)) : bus.colour_in;
                else
                    m_col <= '0;
                m_sh <= in_rg(mh(t), HV + HF, HS) ? POL : ~POL;
                m_sv <= in_rg(mv(t), VV + VF, VS) ? POL : ~POL;
            end
            t <= t + 1;
        end
    end

    task automatic test_reset();
        int n;
        reset = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        total += 7;
        if (bus.address_h !== '0) begin bad++; $display("FAIL rst_addr_h got %0h want 0", bus.address_h); end
        if (bus.address_v !== '0) begin bad++; $display("FAIL rst_addr_v got %0h want 0", bus.address_v); end
        if (bus.colour_out !== '0) begin bad++; $display("FAIL rst_colour got %0h want 0", bus.colour_out); end
        if (bus.sync_h !== ~POL) begin bad++; $display("FAIL rst_sync_h got %b want %b", bus.sync_h, ~POL); end
        if (bus.sync_v !== ~POL) begin bad++; $display("FAIL rst_sync_v got %b want %b", bus.sync_v, ~POL); end
        if (bus.pixel_en !== 1'b0) begin bad++; $display("FAIL rst_pixel_en got %b want 0", bus.pixel_en); end
        if (bus.frame_start !== 1'b0) begin bad++; $display("FAIL rst_frame_start got %b want 0", bus.frame_start); end
        reset = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.pixel_en !== 1'b1 && n < 4 * DIV);
        total += 2;
        if (n != DIV) begin bad++; $display("FAIL first_pixel_en got %0d cycles want %0d", n, DIV); end
        if (bus.frame_start !== 1'b1) begin bad++; $display("FAIL first_frame_start got %b want 1", bus.frame_start); end
    endtask

    task automatic test_frames(input int ncyc, input bit addr_colour, input bit tp);
        logic          exp_pe;
        logic          exp_de;
        logic [HW-1:0] eh;
        logic [VW-1:0] ev;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            exp_pe = m_pe(t);
            eh     = HW'(mh(t));
            ev     = VW'(mv(t));
            exp_de = (mh(t) < HV) && (mv(t) < VV);
            total += 8;
            if (bus.address_h !== eh) begin bad++; $display("FAIL addr_h t=%0d got %0d want %0d", t, bus.address_h, eh); end
            if (bus.address_v !== ev) begin bad++; $display("FAIL addr_v t=%0d got %0d want %0d", t, bus.address_v, ev); end
            if (bus.pixel_en !== exp_pe) begin bad++; $display("FAIL pixel_en t=%0d got %b want %b", t, bus.pixel_en, exp_pe); end
            if (bus.display_en !== exp_de) begin bad++; $display("FAIL display_en t=%0d got %b want %b", t, bus.display_en, exp_de); end
            if (bus.frame_start !== (exp_pe && eh == '0 && ev == '0)) begin
                bad++; $display("FAIL frame_start t=%0d got %b want %b", t, bus.frame_start, exp_pe && eh == '0 && ev == '0);
            end
            if (bus.colour_out !== m_col) begin bad++; $display("FAIL colour_out t=%0d got %0h want %0h", t, bus.colour_out, m_col); end
            if (bus.sync_h !== m_sh) begin bad++; $display("FAIL sync_h t=%0d got %b want %b", t, bus.sync_h, m_sh); end
            if (bus.sync_v !== m_sv) begin bad++; $display("FAIL sync_v t=%0d got %b want %b", t, bus.sync_v, m_sv); end
            tp_drv = tp;
            if (addr_colour)
                bus.colour_in = {bus.address_h[3:0], bus.address_v[3:0], 4'hA};
            else
                bus.colour_in = CW'($urandom);
        end
    endtask

    task automatic test_frame_period();
        int n;
        int sh;
        int sv;
        n = 0;
        while (bus.frame_start !== 1'b1 && n < 2 * FrameClks) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus.frame_start !== 1'b1) begin
            bad++; $display("FAIL frame_start_seen got 0 want 1");
        end else begin
            n = 0; sh = 0; sv = 0;
            do begin
                @(negedge clk);
                n++;
                if (bus.sync_h === POL) sh++;
                if (bus.sync_v === POL) sv++;
            end while (bus.frame_start !== 1'b1 && n < 2 * FrameClks);
            total += 3;
            if (n != FrameClks) begin bad++; $display("FAIL frame_period got %0d want %0d", n, FrameClks); end
            if (sh != HS * VT * DIV) begin bad++; $display("FAIL sync_h_cycles got %0d want %0d", sh, HS * VT * DIV); end
            if (sv != VS * HT * DIV) begin bad++; $display("FAIL sync_v_cycles got %0d want %0d", sv, VS * HT * DIV); end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        n = 0;
        while (!(bus.sync_h === POL && bus.sync_v === POL) && n < 2 * FrameClks) begin
            @(negedge clk);
            bus.colour_in = CW'($urandom);
            n++;
        end
        total++;
        if (!(bus.sync_h === POL && bus.sync_v === POL)) begin
            bad++; $display("FAIL mid_sync_seen got %b%b want both active", bus.sync_h, bus.sync_v);
        end
        reset = 1'b1;
        @(negedge clk);
        total += 6;
        if (bus.address_h !== '0) begin bad++; $display("FAIL mid_addr_h got %0h want 0", bus.address_h); end
        if (bus.address_v !== '0) begin bad++; $display("FAIL mid_addr_v got %0h want 0", bus.address_v); end
        if (bus.colour_out !== '0) begin bad++; $display("FAIL mid_colour got %0h want 0", bus.colour_out); end
        if (bus.sync_h !== ~POL) begin bad++; $display("FAIL mid_sync_h got %b want %b", bus.sync_h, ~POL); end
        if (bus.sync_v !== ~POL) begin bad++; $display("FAIL mid_sync_v got %b want %b", bus.sync_v, ~POL); end
        if (bus.pixel_en !== 1'b0) begin bad++; $display("FAIL mid_pixel_en got %b want 0", bus.pixel_en); end
        reset = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.frame_start !== 1'b1 && n < 4 * DIV);
        total++;
        if (n != DIV) begin bad++; $display("FAIL mid_restart got %0d cycles want %0d", n, DIV); end
    endtask

    initial begin
        reset         = 1'b1;
        tp_drv        = 1'b0;
        bus.colour_in = '0;
        test_reset();
        test_frames(FrameClks + 40, 1'b1, 1'b0);
        test_frames(FrameClks, 1'b0, 1'b0);
        test_frame_period();
        test_reset_mid();
        test_frames(FrameClks + 10, 1'b0, 1'b0);
`ifdef VGA_TEST_PATTERN_EN
        test_frames(FrameClks + 10, 1'b0, 1'b1);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
